// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder/subtractor with a valid/ready request side and a
// valid/ready result side. A single 1-bit full-adder slice is reused once per
// clock, LSB first, so an operation takes exactly WIDTH cycles in RUN.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are 1. start_ready is high only in IDLE; done_valid is high only in
// DONE, and the result is held stable until done_ready is seen at an edge.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  request presents an operation
//   start_ready  block can accept an operation (IDLE)
//   a, b         operands (WIDTH bits)
//   cin          carry-in for addition (ignored when sub=1)
//   sub          1: a-b, 0: a+b+cin
//   sum          result (WIDTH bits); unprocessed bits read 0 during RUN
//   cout         final carry-out (for subtraction 1 means no borrow)
//   ovf          signed overflow
//   done_valid   result available (DONE)
//   done_ready   consumer takes the result
//   busy         operation in progress or result pending
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   // Counter holds 0..WIDTH so it can never wrap.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] bit_mask;
   logic             a_bit;
   logic             b_bit;
   logic             ha1_s;
   logic             ha1_c;
   logic             ha2_s;
   logic             ha2_c;
   logic             fa_co;

   // One-hot select of the bit being processed this cycle; also used to
   // write the result bit in place so higher bits stay 0 until reached.
   always_comb begin
      bit_mask = WIDTH'(1) << cnt;
      a_bit    = |(op_a & bit_mask);
      b_bit    = |(op_b & bit_mask);
   end

   // The single full-adder slice: two half adders plus an OR for the carry.
   always_comb begin
      ha1_s = a_bit ^ b_bit;
      ha1_c = a_bit & b_bit;
      ha2_s = ha1_s ^ carry;
      ha2_c = ha1_s & carry;
      fa_co = ha1_c | ha2_c;
   end

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign done_valid  = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  // Subtraction is a + ~b + 1: invert b and force carry-in.
                  op_a  <= a;
                  op_b  <= b ^ {WIDTH{sub}};
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  ovf   <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= sum | (bit_mask & {WIDTH{ha2_s}});
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB here.
                  cout  <= fa_co;
                  ovf   <= carry ^ fa_co;
                  state <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
